rr_mux_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one W-bit output channel between four valid/ready requesters.
- The 4:1 data select is driven by the arbiter's grant, followed by a one-deep registered output stage.
- Sits in front of any single-consumer resource that four producers must time-share, replacing a free-running mux select with fair, handshaked sequencing.

---
 rtl/rr_mux_arbiter_4_pkg.sv | 19 +
 rtl/rr_mux_arbiter_4_pick.sv | 25 ++
 rtl/rr_mux_arbiter_4.sv | 63 ++++++
 tb/tb_rr_mux_arbiter_4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared types for the four-way round-robin arbiter with a registered output mux.
package rr_mux_pkg;

   localparam int N_REQ = 4;

   // One index type covers the last-grant pointer, the current grant and out_sel.
   typedef logic [1:0] req_idx_t;

   localparam req_idx_t PTR_RESET = 2'd3;

   // Turns a requester index into its single ready bit.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input req_idx_t idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_pick.sv
// Rotating-priority picker: the first valid requester after ptr wins, and ptr itself comes last.
module rr_pick_4
   import rr_mux_pkg::*;
(
   input  logic [N_REQ-1:0] in_valid,
   input  req_idx_t         ptr,
   output logic             grant_valid,
   output req_idx_t         grant_idx
);

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      for (int k = 1; k <= N_REQ; k++) begin
         req_idx_t cand;
         // Two-bit wrap makes offset 4 land back on ptr, the lowest-priority slot.
         cand = ptr + req_idx_t'(k);
         if (!grant_valid && in_valid[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four requesters share one W-bit channel via round-robin grant and a one-deep output register.
module rr_mux_arbiter_4
   import rr_mux_pkg::*;
#(
   parameter int W = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       in_valid,
   input  logic [N_REQ-1:0][W-1:0] in_data,
   output logic [N_REQ-1:0]       in_ready,
   output logic                   out_valid,
   output logic [W-1:0]           out_data,
   output logic [1:0]             out_sel,
   input  logic                   out_ready
);

   // Handshake: a word moves on any edge where valid and ready are both high; a
   // producer holds valid/data until it sees ready, and ready never depends on
   // anything registered downstream except out_valid.
   req_idx_t ptr;
   logic     grant_valid;
   req_idx_t grant_idx;
   logic     load_en;
   logic     in_xfer;
   logic     out_xfer;

   rr_pick_4 u_pick (
      .in_valid    (in_valid),
      .ptr         (ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      load_en  = !out_valid || out_ready;
      in_xfer  = grant_valid && load_en && !rst;
      out_xfer = out_valid && out_ready;
      in_ready = '0;
      if (in_xfer) begin
         in_ready = idx_to_onehot(grant_idx);
      end
   end

   // Reset wins over any pending transfer; a reload keeps out_valid high on a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= PTR_RESET;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[grant_idx];
         out_sel   <= grant_idx;
         ptr       <= grant_idx;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: directed vector table, then random traffic against a reference model.
module tb_rr_mux_arbiter_4;

   localparam int W = 8;

   typedef struct {
      logic           rst;
      logic [3:0]     valid;
      logic           ordy;
      logic [31:0]    data;
      logic [3:0]     exp_ready;
      logic           exp_ov;
      logic [W-1:0]   exp_od;
      logic [1:0]     exp_os;
   } vec_t;

   logic               clk;
   logic               rst;
   logic [3:0]         in_valid;
   logic [3:0][W-1:0]  in_data;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic [1:0]         out_sel;
   logic               out_ready;

   int n_checks;
   int n_fail;
   vec_t vecs[$];
   logic [W-1:0] exp_q[$];

   rr_mux_arbiter_4 #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic o, input logic [31:0] d,
                      input logic [3:0] er, input logic eov, input logic [W-1:0] eod,
                      input logic [1:0] eos);
      vec_t x;
      x.rst = r; x.valid = v; x.ordy = o; x.data = d;
      x.exp_ready = er; x.exp_ov = eov; x.exp_od = eod; x.exp_os = eos;
      vecs.push_back(x);
   endtask

   // driver: apply one vector at the falling edge, check ready then registered outputs
   task automatic apply(input vec_t x, input int row);
      @(negedge clk);
      rst = x.rst; in_valid = x.valid; out_ready = x.ordy; in_data = x.data;
      #1;
      check($sformatf("row%0d_in_ready", row), 32'(in_ready), 32'(x.exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_out_valid", row), 32'(out_valid), 32'(x.exp_ov));
      check($sformatf("row%0d_out_data", row), 32'(out_data), 32'(x.exp_od));
      check($sformatf("row%0d_out_sel", row), 32'(out_sel), 32'(x.exp_os));
   endtask

   // reference model state
   int           ptr_m;
   logic         ov_m;
   logic [W-1:0] od_m;
   int           os_m;

   task automatic random_phase(input int cycles);
      for (int cyc = 0; cyc < cycles; cyc++) begin
         bit found;
         int g;
         logic [3:0] exp_ready;
         @(negedge clk);
         rst       = (cyc == 0) || ($urandom_range(0, 49) == 0);
         in_valid  = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) in_data[i] = W'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         found = 0;
         g = 0;
         for (int off = 1; off <= 4; off++) begin
            if (!found && in_valid[(ptr_m + off) % 4]) begin
               found = 1;
               g = (ptr_m + off) % 4;
            end
         end
         exp_ready = 4'b0000;
         if (!rst && found && (!ov_m || out_ready)) exp_ready = 4'(1 << g);
         check("rand_in_ready", 32'(in_ready), 32'(exp_ready));
         if (!rst && ov_m && out_ready && exp_q.size() > 0) begin
            logic [W-1:0] w;
            w = exp_q.pop_front();
            check("rand_drain_data", 32'(out_data), 32'(w));
         end
         if (rst) begin
            ov_m = 0; od_m = '0; os_m = 0; ptr_m = 3;
            exp_q.delete();
         end else if (exp_ready != 4'b0000) begin
            ov_m = 1; od_m = in_data[g]; os_m = g; ptr_m = g;
            exp_q.push_back(in_data[g]);
         end else if (ov_m && out_ready) begin
            ov_m = 0;
         end
         @(posedge clk);
         #1;
         check("rand_out_valid", 32'(out_valid), 32'(ov_m));
         check("rand_out_data", 32'(out_data), 32'(od_m));
         check("rand_out_sel", 32'(out_sel), 32'(os_m));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      ptr_m = 3; ov_m = 0; od_m = '0; os_m = 0;

      // reset, then idle
      add(1, 4'h0, 0, 32'h44332211, 4'b0000, 0, 8'h00, 0);
      add(1, 4'h0, 0, 32'h44332211, 4'b0000, 0, 8'h00, 0);
      add(1, 4'h0, 0, 32'h44332211, 4'b0000, 0, 8'h00, 0);
      add(0, 4'h0, 1, 32'h44332211, 4'b0000, 0, 8'h00, 0);
      // full rotation starting at requester 0
      add(0, 4'hF, 1, 32'h44332211, 4'b0001, 1, 8'h11, 0);
      add(0, 4'hF, 1, 32'h44332211, 4'b0010, 1, 8'h22, 1);
      add(0, 4'hF, 1, 32'h44332211, 4'b0100, 1, 8'h33, 2);
      add(0, 4'hF, 1, 32'h44332211, 4'b1000, 1, 8'h44, 3);
      add(0, 4'hF, 1, 32'h44332211, 4'b0001, 1, 8'h11, 0);
      add(0, 4'hF, 1, 32'h44332211, 4'b0010, 1, 8'h22, 1);
      // backpressure holds b, then c follows
      add(0, 4'hF, 0, 32'h44332211, 4'b0000, 1, 8'h22, 1);
      add(0, 4'hF, 0, 32'h44332211, 4'b0000, 1, 8'h22, 1);
      add(0, 4'hF, 0, 32'h44332211, 4'b0000, 1, 8'h22, 1);
      add(0, 4'hF, 0, 32'h44332211, 4'b0000, 1, 8'h22, 1);
      add(0, 4'hF, 1, 32'h44332211, 4'b0100, 1, 8'h33, 2);
      add(0, 4'h0, 1, 32'h44332211, 4'b0000, 0, 8'h33, 2);
      // sparse requesters 0 and 2 after a fresh reset
      add(1, 4'h0, 1, 32'h44092205, 4'b0000, 0, 8'h00, 0);
      add(0, 4'h5, 1, 32'h44092205, 4'b0001, 1, 8'h05, 0);
      add(0, 4'h5, 1, 32'h44092205, 4'b0100, 1, 8'h09, 2);
      add(0, 4'h5, 1, 32'h44092205, 4'b0001, 1, 8'h05, 0);
      add(0, 4'h5, 1, 32'h44092205, 4'b0100, 1, 8'h09, 2);
      // reset lands while a word is held and requester 1 is next
      add(0, 4'hF, 1, 32'h44332211, 4'b1000, 1, 8'h44, 3);
      add(0, 4'hF, 1, 32'h44332211, 4'b0001, 1, 8'h11, 0);
      add(1, 4'hF, 1, 32'h44332211, 4'b0000, 0, 8'h00, 0);
      add(0, 4'hF, 1, 32'h44332211, 4'b0001, 1, 8'h11, 0);
      // lone requester 3, data tracked with one cycle of delay
      add(0, 4'h8, 1, 32'h5A000000, 4'b1000, 1, 8'h5A, 3);
      add(0, 4'h8, 1, 32'hA5000000, 4'b1000, 1, 8'hA5, 3);
      add(0, 4'h8, 1, 32'h3C000000, 4'b1000, 1, 8'h3C, 3);
      add(0, 4'h0, 0, 32'h00000000, 4'b0000, 1, 8'h3C, 3);
      add(0, 4'h0, 1, 32'h00000000, 4'b0000, 0, 8'h3C, 3);

      for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r);

      random_phase(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, limit 200000 ns");
      $fatal(1);
   end

endmodule
